// File: rtl/bfly4_out_serializer_if.sv
// rtl/bfly4_out_serializer_if.sv - parallel frame input and serial sample output bundle
interface bfly4_out_serializer_if #(
  parameter int DATA_WIDTH  = 14,
  parameter int FRAME_CNT_W = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  in_re [0:3];
  logic signed [DATA_WIDTH-1:0]  in_im [0:3];
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  out_re;
  logic signed [DATA_WIDTH-1:0]  out_im;
  logic [1:0]                    out_idx;
  logic                          out_last;
  logic [FRAME_CNT_W-1:0]        out_frame;

  // Producer of frames and consumer of samples.
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, out_frame
  );

  // The serializer itself.
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, out_frame
  );
endinterface

// File: rtl/bfly4_out_serializer.sv
// rtl/bfly4_out_serializer.sv - two-frame buffer turning 4-lane butterfly results into a sample stream
module bfly4_out_serializer #(
  parameter int DATA_WIDTH  = 14,
  parameter bit BITREV      = 1'b0,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  bfly4_out_serializer_if.slave  io,
  output logic                   busy
);

  logic signed [DATA_WIDTH-1:0] buf_re [0:1][0:3];
  logic signed [DATA_WIDTH-1:0] buf_im [0:1][0:3];
  logic [1:0]                   count;
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   rd_beat;
  logic [FRAME_CNT_W-1:0]       frame_cnt;

  logic       in_ready;
  logic       out_valid;
  logic       accept;
  logic       pop;
  logic       pop_last;
  logic [1:0] lane;

  // Ready comes from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = io.in_valid & in_ready;
  assign pop       = out_valid & io.out_ready;
  assign pop_last  = pop & (rd_beat == 2'd3);
  assign lane      = BITREV ? {rd_beat[0], rd_beat[1]} : rd_beat;
  assign busy      = out_valid;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;

  // Present the current lane of the head frame; outputs read as zero when idle.
  always_comb begin
    io.out_re    = '0;
    io.out_im    = '0;
    io.out_idx   = 2'd0;
    io.out_last  = 1'b0;
    io.out_frame = frame_cnt;
    if (out_valid) begin
      io.out_re   = buf_re[rd_ptr][lane];
      io.out_im   = buf_im[rd_ptr][lane];
      io.out_idx  = lane;
      io.out_last = (rd_beat == 2'd3);
    end
  end

  // Capture a whole frame into the free entry; the entry being read is never the write target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < 2; e++) begin
        for (int l = 0; l < 4; l++) begin
          buf_re[e][l] <= '0;
          buf_im[e][l] <= '0;
        end
      end
    end else if (accept) begin
      for (int l = 0; l < 4; l++) begin
        buf_re[wr_ptr][l] <= io.in_re[l];
        buf_im[wr_ptr][l] <= io.in_im[l];
      end
    end
  end

  // Pointer, occupancy, beat and frame-sequence bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_beat   <= 2'd0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_beat <= rd_beat + 2'd1;
      end
      if (pop_last) begin
        rd_ptr    <= ~rd_ptr;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      // Accept and final-beat pop in one cycle cancel out.
      case ({accept, pop_last})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bfly4_out_serializer.sv
// tb/tb_bfly4_out_serializer.sv - scoreboard bench for natural and bit-reversed serializers
module tb_bfly4_out_serializer;

  localparam int DW = 14;
  localparam int FW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn;
  logic                 in_valid;
  logic                 out_ready;
  logic signed [DW-1:0] in_re [0:3];
  logic signed [DW-1:0] in_im [0:3];
  logic                 busy0;
  logic                 busy1;

  bfly4_out_serializer_if #(.DATA_WIDTH(DW), .FRAME_CNT_W(FW)) if0 ();
  bfly4_out_serializer_if #(.DATA_WIDTH(DW), .FRAME_CNT_W(FW)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if1.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign if0.in_re[g] = in_re[g];
    assign if0.in_im[g] = in_im[g];
    assign if1.in_re[g] = in_re[g];
    assign if1.in_im[g] = in_im[g];
  end

  bfly4_out_serializer #(.DATA_WIDTH(DW), .BITREV(1'b0), .FRAME_CNT_W(FW)) dut0 (
    .clk(clk), .rstn(rstn), .io(if0), .busy(busy0)
  );
  bfly4_out_serializer #(.DATA_WIDTH(DW), .BITREV(1'b1), .FRAME_CNT_W(FW)) dut1 (
    .clk(clk), .rstn(rstn), .io(if1), .busy(busy1)
  );

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [1:0]           idx;
    logic                 last;
    logic [FW-1:0]        frame;
  } exp_t;

  exp_t          sb [2][$];
  logic [FW-1:0] fcnt [2];
  int            n_pass  = 0;
  int            n_total = 0;

  // Scoreboard: push expected beats on every accept, compare and pop on every transfer.
  always @(negedge clk) begin
    logic                 v, ir, lst;
    logic signed [DW-1:0] re, im;
    logic [1:0]           idx, bb, ln;
    logic [FW-1:0]        fr;
    exp_t                 e;
    if (!rstn) begin
      sb[0].delete();
      sb[1].delete();
      fcnt[0] = '0;
      fcnt[1] = '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        v   = d ? if1.out_valid : if0.out_valid;
        ir  = d ? if1.in_ready  : if0.in_ready;
        re  = d ? if1.out_re    : if0.out_re;
        im  = d ? if1.out_im    : if0.out_im;
        idx = d ? if1.out_idx   : if0.out_idx;
        lst = d ? if1.out_last  : if0.out_last;
        fr  = d ? if1.out_frame : if0.out_frame;
        n_total++;
        if (v !== (sb[d].size() != 0))
          $display("FAIL sb_valid dut%0d: out_valid=%b required=%b", d, v, (sb[d].size() != 0));
        else
          n_pass++;
        if (v && sb[d].size() != 0) begin
          e = sb[d][0];
          n_total++;
          if ({re, im, idx, lst, fr} !== {e.re, e.im, e.idx, e.last, e.frame})
            $display("FAIL sb_beat dut%0d: re=%0d im=%0d idx=%0d last=%b frame=%0d required re=%0d im=%0d idx=%0d last=%b frame=%0d",
                     d, re, im, idx, lst, fr, e.re, e.im, e.idx, e.last, e.frame);
          else
            n_pass++;
          if (out_ready) void'(sb[d].pop_front());
        end else if (!v) begin
          n_total++;
          if ({re, im, idx, lst} !== '0)
            $display("FAIL sb_idle_zero dut%0d: re=%0d im=%0d idx=%0d last=%b required all 0", d, re, im, idx, lst);
          else
            n_pass++;
        end
        if (in_valid && ir) begin
          for (int b = 0; b < 4; b++) begin
            bb = b[1:0];
            ln = d ? {bb[0], bb[1]} : bb;
            e.re    = in_re[ln];
            e.im    = in_im[ln];
            e.idx   = ln;
            e.last  = (b == 3);
            e.frame = fcnt[d];
            sb[d].push_back(e);
          end
          fcnt[d] = fcnt[d] + FW'(1);
        end
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < 4; i++) begin
      in_re[i] = DW'($urandom);
      in_im[i] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sb[0].size() == 0 && sb[1].size() == 0 && !if0.out_valid && !if1.out_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rand_data();
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rstn      = 1'b1;
    @(negedge clk);
    n_total++;
    if ({if0.in_ready, if0.out_valid, if0.out_re, if0.out_im, if0.out_frame, busy0} !== {1'b1, 1'b0, DW'(0), DW'(0), FW'(0), 1'b0})
      $display("FAIL reset_dut0: rdy=%b vld=%b re=%0d im=%0d frame=%0d busy=%b required 1 0 0 0 0 0",
               if0.in_ready, if0.out_valid, if0.out_re, if0.out_im, if0.out_frame, busy0);
    else n_pass++;
    n_total++;
    if ({if1.in_ready, if1.out_valid, if1.out_re, if1.out_im, if1.out_frame, busy1} !== {1'b1, 1'b0, DW'(0), DW'(0), FW'(0), 1'b0})
      $display("FAIL reset_dut1: rdy=%b vld=%b re=%0d im=%0d frame=%0d busy=%b required 1 0 0 0 0 0",
               if1.in_ready, if1.out_valid, if1.out_re, if1.out_im, if1.out_frame, busy1);
    else n_pass++;
  endtask

  task automatic test_single();
    int re_nat [4] = '{100, -200, 300, -400};
    int im_nat [4] = '{1, 2, 3, 4};
    int re_rev [4] = '{100, 300, -200, -400};
    int im_rev [4] = '{1, 3, 2, 4};
    int ix_rev [4] = '{0, 2, 1, 3};
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_re[i] = DW'(re_nat[i]);
      in_im[i] = DW'(im_nat[i]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rand_data();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_total++;
      if ({if0.out_valid, if0.out_re, if0.out_im, if0.out_idx, if0.out_last, if0.out_frame} !==
          {1'b1, DW'(re_nat[b]), DW'(im_nat[b]), 2'(b), (b == 3), FW'(0)})
        $display("FAIL single_nat beat%0d: vld=%b re=%0d im=%0d idx=%0d last=%b frame=%0d required re=%0d im=%0d idx=%0d",
                 b, if0.out_valid, if0.out_re, if0.out_im, if0.out_idx, if0.out_last, if0.out_frame, re_nat[b], im_nat[b], b);
      else n_pass++;
      n_total++;
      if ({if1.out_valid, if1.out_re, if1.out_im, if1.out_idx, if1.out_last, if1.out_frame} !==
          {1'b1, DW'(re_rev[b]), DW'(im_rev[b]), 2'(ix_rev[b]), (b == 3), FW'(0)})
        $display("FAIL single_rev beat%0d: vld=%b re=%0d im=%0d idx=%0d last=%b frame=%0d required re=%0d im=%0d idx=%0d",
                 b, if1.out_valid, if1.out_re, if1.out_im, if1.out_idx, if1.out_last, if1.out_frame, re_rev[b], im_rev[b], ix_rev[b]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({if0.out_valid, if1.out_valid, busy0, busy1} !== 4'b0000)
      $display("FAIL single_after: vld0=%b vld1=%b busy0=%b busy1=%b required all 0", if0.out_valid, if1.out_valid, busy0, busy1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] a_re0, a_im0;
    bit ok;
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_data();
    a_re0 = in_re[0];
    a_im0 = in_im[0];
    @(posedge clk); #1;
    rand_data();
    @(posedge clk); #1;
    rand_data();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({if0.in_ready, if1.in_ready, busy0, busy1} !== 4'b0011)
        $display("FAIL full_flags cyc%0d: rdy0=%b rdy1=%b busy0=%b busy1=%b required 0 0 1 1", c, if0.in_ready, if1.in_ready, busy0, busy1);
      else n_pass++;
      n_total++;
      if ({if0.out_valid, if0.out_re, if0.out_im, if0.out_idx, if0.out_frame} !== {1'b1, a_re0, a_im0, 2'd0, FW'(0)})
        $display("FAIL stall_hold cyc%0d: vld=%b re=%0d im=%0d idx=%0d frame=%0d required 1 %0d %0d 0 0",
                 c, if0.out_valid, if0.out_re, if0.out_im, if0.out_idx, if0.out_frame, a_re0, a_im0);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if ({if0.in_ready, if1.in_ready} !== 2'b00)
        $display("FAIL drain_rdy cyc%0d: rdy0=%b rdy1=%b required 0 0", c, if0.in_ready, if1.in_ready);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({if0.in_ready, if1.in_ready} !== 2'b11)
      $display("FAIL reopen_rdy: rdy0=%b rdy1=%b required 1 1", if0.in_ready, if1.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL bp_drain: drained=%b required 1", ok);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int acc = 0, seen = 0, gap = 0, vcyc = 0;
    bit started = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && seen < 257; cyc++) begin
      @(posedge clk); #1;
      in_valid = (acc < 257);
      rand_data();
      @(negedge clk);
      if (in_valid && if0.in_ready) acc++;
      if (if0.out_valid) begin
        started = 1'b1;
        vcyc++;
        if (if0.out_last) begin
          seen++;
          if (seen == 256) begin
            n_total++;
            if ({if0.out_frame, if1.out_frame} !== {FW'(255), FW'(255)})
              $display("FAIL wrap_255: frame0=%0d frame1=%0d required 255", if0.out_frame, if1.out_frame);
            else n_pass++;
          end
          if (seen == 257) begin
            n_total++;
            if ({if0.out_frame, if1.out_frame} !== {FW'(0), FW'(0)})
              $display("FAIL wrap_0: frame0=%0d frame1=%0d required 0", if0.out_frame, if1.out_frame);
            else n_pass++;
          end
        end
      end else if (started) begin
        gap++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (seen !== 257) $display("FAIL wrap_frames: frames=%0d required 257", seen);
    else n_pass++;
    n_total++;
    if (gap !== 0 || vcyc !== 1028) $display("FAIL wrap_bubbles: gaps=%0d valid_cycles=%0d required 0 1028", gap, vcyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] d_re0;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    rand_data();
    @(posedge clk); #1;
    rand_data();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({if0.out_valid, if0.out_idx, busy0} !== {1'b1, 2'd2, 1'b1})
      $display("FAIL mid_pre: vld=%b idx=%0d busy=%b required 1 2 1", if0.out_valid, if0.out_idx, busy0);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++;
    if ({if0.out_valid, if1.out_valid, busy0, busy1, if0.in_ready, if0.out_idx} !== {4'b0000, 1'b1, 2'd0})
      $display("FAIL mid_async: vld0=%b vld1=%b busy0=%b busy1=%b rdy=%b idx=%0d required 0 0 0 0 1 0",
               if0.out_valid, if1.out_valid, busy0, busy1, if0.in_ready, if0.out_idx);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_total++;
    if ({if0.out_valid, if1.out_valid} !== 2'b00)
      $display("FAIL mid_no_stale: vld0=%b vld1=%b required 0 0", if0.out_valid, if1.out_valid);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b1;
    rand_data();
    d_re0 = in_re[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({if0.out_valid, if0.out_idx, if0.out_frame, if0.out_re, if1.out_idx, if1.out_frame, if1.out_re} !==
        {1'b1, 2'd0, FW'(0), d_re0, 2'd0, FW'(0), d_re0})
      $display("FAIL mid_restart: vld=%b idx=%0d frame=%0d re=%0d idx1=%0d frame1=%0d re1=%0d required 1 0 0 %0d",
               if0.out_valid, if0.out_idx, if0.out_frame, if0.out_re, if1.out_idx, if1.out_frame, if1.out_re, d_re0);
    else n_pass++;
    wait_drain(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL mid_drain: drained=%b required 1", ok);
    else n_pass++;
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_re[i] = '0;
      in_im[i] = '0;
    end
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bfly4_out_serializer.md
Name: bfly4_out_serializer

Overview:
Sink-side companion to the 4-point butterfly stage. It accepts one butterfly result frame per handshake: four lanes of real and imaginary data, presented in parallel. It buffers up to two frames and streams them out one complex sample per cycle under valid/ready flow control, with lane index, end-of-frame and frame-count sideband. It sits between the butterfly pipeline and the serial post-processing / output datapath.

Parameters:
- DATA_WIDTH, 14, width of each signed re/im sample; matches the butterfly output width.
- BITREV, 0, output lane order. 0 = natural order 0,1,2,3. 1 = bit-reversed order 0,2,1,3.
- FRAME_CNT_W, 8, width of the output frame counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  a parallel frame is present on in_re/in_im.
- in_ready  out  1  block can accept a frame this cycle.
- in_re  in  4 x DATA_WIDTH (signed, unpacked [0:3])  lane real parts.
- in_im  in  4 x DATA_WIDTH (signed, unpacked [0:3])  lane imaginary parts.
- out_valid  out  1  serial sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_re  out  DATA_WIDTH signed  serial real sample.
- out_im  out  DATA_WIDTH signed  serial imaginary sample.
- out_idx  out  2  lane index of the current sample.
- out_last  out  1  high on the final sample of a frame.
- out_frame  out  FRAME_CNT_W  sequence number of the frame being emitted.
- busy  out  1  at least one frame is buffered.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rstn); all flops clear immediately when rstn goes low.
- Storage: two-entry frame buffer (ping-pong), each entry holding 4 re and 4 im samples. Control state: wr_ptr (1b), rd_ptr (1b), count (0..2), beat counter rd_beat (2b), frame_cnt.
- Reset values: count=0, wr_ptr=0, rd_ptr=0, rd_beat=0, frame_cnt=0, buffer contents=0. Outputs: in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, out_frame=0, busy=0.
- in_ready = (count < 2), derived from registered count only. There is no combinational path from out_ready to in_ready.
- Accept:
  - Occurs when in_valid & in_ready at a rising edge.
  - All 8 samples are written into entry wr_ptr; wr_ptr toggles and count increments.
  - Input data is don't-care when no accept occurs.
- Emit:
  - out_valid = (count > 0).
  - Current lane = rd_beat for BITREV=0, or bit-reverse(rd_beat) for BITREV=1.
  - out_re/out_im = entry[rd_ptr][lane]; out_idx = lane; out_last = (rd_beat == 3); out_frame = frame_cnt.
  - When out_valid=0, out_re, out_im, out_idx and out_last are driven to 0.
- Transfer: when out_valid & out_ready, rd_beat increments.
  - If rd_beat was 3, rd_beat wraps to 0, rd_ptr toggles, count decrements and frame_cnt increments. frame_cnt wraps modulo 2^FRAME_CNT_W.
- Stall: while out_valid & !out_ready, all out_* signals hold stable (AXI-stream rule).
- Simultaneous accept and final-beat pop in the same cycle: count is unchanged and both pointers advance.
- When count=2, in_ready=0 even if a pop occurs that cycle. The next frame is accepted no earlier than the following cycle.
- Latency: a frame accepted at edge N presents lane-0 on out_* during cycle N+1 (when the buffer was empty).
- Throughput: sustained 1 sample/cycle, i.e. 1 frame per 4 cycles. Back-to-back frames emit with no bubble when out_ready stays high.
- Arithmetic: none. Samples pass bit-exact; no sign extension or truncation.
- busy = (count != 0).
- Reset mid-frame: all buffered frames and the partial frame are discarded, with no further beats from them. Counters return to reset values.

Test Plan:
- Reset check: hold rstn=0 with random inputs, then release. Required: in_ready=1, out_valid=0, out_re=out_im=0, out_frame=0, busy=0.
- Single frame, BITREV=0: in_re={100,-200,300,-400}, in_im={1,2,3,4}, out_ready=1, accepted at edge N. Required: cycles N+1..N+4 output re 100,-200,300,-400; im 1,2,3,4; idx 0,1,2,3; out_last only on the 4th beat; out_frame=0. out_valid=0 at N+5.
- BITREV=1 with the same frame. Required: re 100,300,-200,-400; idx 0,2,1,3; out_last on the -400 beat.
- Backpressure/full: out_ready=0, offer 3 frames continuously. Required: first two accepted, then in_ready=0 and busy=1; out_* hold lane-0 of frame 0 unchanged.
  - Then set out_ready=1. Required: in_ready still 0 in the cycle of frame 0's last-beat pop, third frame accepted the next cycle, and out_frame sequence 0,1,2 with no data loss or reordering.
- Frame counter wrap, FRAME_CNT_W=8: stream 257 frames at full rate. Required: out_frame runs 0..255, then 0 on frame 257; no bubbles between frames.
- Reset mid-operation: assert rstn during beat 2 of a frame with a second frame buffered. Required: immediate out_valid=0, count=0. After release, a new frame is output starting at idx 0 with out_frame=0.
